// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, frame geometry and default baud divisor.
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_BYTES_PER_WORD = 4;
  localparam int UART_CLKS_PER_BIT   = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-interval counter: tick pulses on count CLKS_PER_BIT-1 and the count wraps to 0;
// clr holds the count at 0. Shared by the transmitter and the decode receiver.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_encode.sv
// UART transmitter: serialises 32-bit words as four LSB-first byte frames (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit per byte (8E1).
module uart_encode
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        tx,
  output logic        busy
);

  uart_tx_state_t state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [1:0]     byte_q, byte_d;
  logic [2:0]     bit_q, bit_d;
  logic           tx_q, tx_d;
  logic           tick;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_IDLE),
    .tick(tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          word_d  = din;
          byte_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          word_d = word_q >> 1;
`ifdef UART_TX_PARITY_EN
          par_d  = par_q ^ word_q[0];
`endif
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (byte_q == 2'(UART_BYTES_PER_WORD - 1)) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = word_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign din_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;

endmodule

// File: tb/tb_uart_encode.sv
// Directed bench for uart_encode at CLKS_PER_BIT=4; checks tx cycle by cycle against framed expected bytes.
// Build with UART_TX_PARITY_EN defined to expect 8E1 frames.
module tb_uart_encode;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        tx;
  logic        busy;

  int n_checks;
  int n_fail;

  uart_encode #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: tx must hold exp for CPB cycles while the block is busy.
  task automatic expect_bit(input string tag, input logic exp);
    for (int c = 0; c < CPB; c++) begin
      check(tag, 32'(tx), 32'(exp));
      check("busy", 32'(busy), 32'd1);
      if (c == 0) check("din_ready_busy", 32'(din_ready), 32'd0);
      tick();
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    expect_bit("start", 1'b0);
    for (int k = 0; k < 8; k++) expect_bit($sformatf("data_%02h_bit%0d", b, k), b[k]);
`ifdef UART_TX_PARITY_EN
    expect_bit($sformatf("parity_%02h", b), ^b);
`endif
    expect_bit("stop", 1'b1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(din_ready), 32'd1);
  endtask

  // Present a word in an idle cycle; returns in the first start-bit cycle with din_valid dropped.
  task automatic send_word(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    check("accept_ready", 32'(din_ready), 32'd1);
    check("accept_busy", 32'(busy), 32'd0);
    tick();
    din_valid = 1'b0;
  endtask

  // Mid-bit sampler standing in for the receiver on a loopback.
  task automatic capture_word(output logic [31:0] w);
    w = '0;
    for (int b = 0; b < 4; b++) begin
      repeat (CPB / 2) tick();
      check("cap_start", 32'(tx), 32'd0);
      repeat (CPB - CPB / 2) tick();
      for (int k = 0; k < 8; k++) begin
        repeat (CPB / 2) tick();
        w[8*b+k] = tx;
        repeat (CPB - CPB / 2) tick();
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) tick();
`endif
      repeat (CPB / 2) tick();
      check("cap_stop", 32'(tx), 32'd1);
      repeat (CPB - CPB / 2) tick();
    end
  endtask

  logic [31:0] cap;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    // Reset state, including din_valid ignored while reset is held
    tick();
    din_valid = 1'b1;
    tick();
    expect_idle("reset");
    din_valid = 1'b0;
    rst = 1'b0;
    tick();
    expect_idle("post_reset");

    // Single word 0x000000A5: 160 busy cycles then ready again
    send_word(32'h0000_00A5);
    expect_byte(8'hA5);
    expect_byte(8'h00);
    expect_byte(8'h00);
    expect_byte(8'h00);
    expect_idle("single_end");
    tick();
    expect_idle("single_end2");

    // Back-to-back: din_valid held; one idle cycle separates the words
    din       = 32'h1122_3344;
    din_valid = 1'b1;
    tick();
    din = 32'h5566_7788;
    expect_byte(8'h44);
    expect_byte(8'h33);
    expect_byte(8'h22);
    expect_byte(8'h11);
    expect_idle("b2b_gap");
    tick();
    din_valid = 1'b0;
    expect_byte(8'h88);
    expect_byte(8'h77);
    expect_byte(8'h66);
    expect_byte(8'h55);
    expect_idle("b2b_end");
    tick();

    // New data offered during byte 1 must not disturb the word in flight
    send_word(32'h1234_5678);
    expect_byte(8'h78);
    din       = 32'hFFFF_FFFF;
    din_valid = 1'b1;
    check("ignore_ready", 32'(din_ready), 32'd0);
    expect_byte(8'h56);
    din_valid = 1'b0;
    expect_byte(8'h34);
    expect_byte(8'h12);
    expect_idle("ignore_end");
    tick();

    // Reset asynchronously during byte 2, then restart from byte 0
    send_word(32'hCAFE_F00D);
    expect_byte(8'h0D);
    expect_byte(8'hF0);
    expect_bit("start_b2", 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    expect_idle("rst_release");
    send_word(32'h0000_00C3);
    expect_byte(8'hC3);
    expect_byte(8'h00);
    expect_byte(8'h00);
    expect_byte(8'h00);
    expect_idle("rst_word_end");
    tick();

    // Parity-sensitive bytes 0xA5 (even count) and 0x07 (odd count)
    send_word(32'h0000_07A5);
    expect_byte(8'hA5);
    expect_byte(8'h07);
    expect_byte(8'h00);
    expect_byte(8'h00);
    expect_idle("parity_end");
    tick();

    // Loopback-style reconstruction of 0xDEADBEEF from mid-bit samples
    send_word(32'hDEAD_BEEF);
    capture_word(cap);
    check("loopback_word", cap, 32'hDEAD_BEEF);
    expect_idle("loopback_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
